alarma_sirena: RTL and testbench
================================

Name: alarma_sirena

Overview:
- Sequential responder on the output side of the combinational car-alarm trigger (Y = A&(C|~B)).
- Consumes the trigger line and the driver's arm/disarm requests.
- Applies debounce, an entry-delay window, a time-limited siren and a re-arm holdoff.
- Drives siren, status LED, state code and a saturating alarm-event counter. Sits between the trigger logic and the board outputs.

Parameters:
- DEB_LEN, 4: consecutive high/low trigger samples needed to accept a level (min 1).
- ENTRY_DELAY, 1000: cycles spent in ENTRY before siren (min 1).
- SIREN_TIME, 5000: cycles siren stays on in ALARM (min 1).
- BLINK_DIV, 250: LED toggle period in cycles during ENTRY/ALARM (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- arm  input  1  level request to arm; sampled each edge.
- disarm  input  1  level request to disarm; has priority over everything.
- trigger  input  1  raw alarm condition from trigger logic (already synchronous to clk).
- siren  output  1  siren drive, registered.
- led  output  1  status LED, registered.
- state_o  output  3  current state code, registered.
- alarm_count  output  8  number of ALARM entries since reset, saturating.

Behaviour:
- Interface decided: single clock clk; reset rst_n is asynchronous and active-low.
- Reset: state=DISARMED (3'd0), siren=0, led=0, alarm_count=0, all internal counters 0.
- All outputs are registered and reflect the current state in the same cycle as state_o.
- Debounce: hi_ok asserts on the edge sampling the DEB_LEN-th consecutive trigger=1. lo_ok asserts on the edge sampling the DEB_LEN-th consecutive trigger=0. Any opposite sample clears the run.
- States and codes: DISARMED=0, ARMED=1, ENTRY=2, ALARM=3, HOLDOFF=4; codes 5-7 are illegal and recover to DISARMED.
- Transitions on each edge:
  - disarm=1: go to DISARMED from any state. Wins over arm and over a simultaneous hi_ok.
  - DISARMED: arm=1 goes to ARMED. Trigger is ignored.
  - ARMED: hi_ok goes to ENTRY. Timer loads 0.
  - ENTRY: timer increments. When it reaches ENTRY_DELAY-1, go to ALARM, so ENTRY lasts exactly ENTRY_DELAY cycles. A trigger drop does not cancel ENTRY; only disarm does.
  - ALARM: siren=1 and timer increments. When it reaches SIREN_TIME-1, go to HOLDOFF, so siren is high exactly SIREN_TIME cycles. alarm_count increments on the ENTRY->ALARM edge and saturates at 255.
  - HOLDOFF: siren=0. lo_ok goes to ARMED. If the trigger stays high, remain in HOLDOFF with no re-trigger.
- arm while already ARMED/ENTRY/ALARM/HOLDOFF: ignored.
- LED:
  - DISARMED 0; ARMED 1; HOLDOFF 1.
  - ENTRY and ALARM: toggles every BLINK_DIV cycles, starting at 1 on entry to the state. The blink counter resets on each state change.
- Timer width: $clog2(max(ENTRY_DELAY,SIREN_TIME)+1). Blink counter width: $clog2(BLINK_DIV+1). Neither counter wraps.
- Reset asserted mid-operation (e.g., siren on): outputs drop asynchronously to reset values. After release, the FSM starts in DISARMED regardless of trigger level.

Decomposition:
- Shared package alarma_pkg: state code localparams (S_DISARMED..S_HOLDOFF), width 3; ALARM_CNT_W=8.
- One sub-module alarma_antirrebote(clk, rst_n, din, hi_ok, lo_ok), parameter DEB_LEN. It holds the run counter and last-sample register.
- The FSM, timer, blink counter and event counter stay in alarma_sirena.

Test Plan (DEB_LEN=2, ENTRY_DELAY=4, SIREN_TIME=8, BLINK_DIV=2):
1. Reset, then arm=1 for 1 cycle -> state_o 0->1, led=1, siren=0, alarm_count=0.
2. Armed, trigger pulse of 1 cycle, then trigger=1 for 2 cycles -> pulse ignored. State goes to ENTRY on the 2nd high sample, ALARM exactly 4 cycles later. Siren high exactly 8 cycles, led toggles every 2 cycles, alarm_count=1.
3. After siren timeout with trigger held 1 -> state stays 4 (HOLDOFF), siren=0. Trigger drops to 0 for 2 cycles -> state=1.
4. In ENTRY at timer=2, assert disarm -> next edge state=0, siren never asserts, alarm_count unchanged.
5. arm=1 and disarm=1 together in DISARMED; also disarm coincident with hi_ok in ARMED -> state=0 in both cases.
6. Drive 256 full alarm cycles -> alarm_count saturates at 255. Assert rst_n=0 mid-ALARM -> siren=0 and state_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarma_pkg.sv
// Shared definitions for the car-alarm siren responder.
// State codes and the alarm-event counter width.
package alarma_pkg;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned ALARM_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_DISARMED = 3'd0,
    S_ARMED    = 3'd1,
    S_ENTRY    = 3'd2,
    S_ALARM    = 3'd3,
    S_HOLDOFF  = 3'd4
  } state_t;
endpackage

// File: rtl/alarma_antirrebote.sv
// Trigger debouncer: reports when the current sample completes a run of
// DEB_LEN identical samples (hi_ok for ones, lo_ok for zeros).
module alarma_antirrebote #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic hi_ok,
  output logic lo_ok
);
  localparam int unsigned CW = $clog2(DEB_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(DEB_LEN);

  logic [CW-1:0] run;
  logic [CW-1:0] run_next;
  logic          last;

  // Run length including the sample being taken now, saturating at DEB_LEN.
  always_comb begin
    run_next = CW'(1);
    if (din == last) begin
      run_next = (run == RUN_MAX) ? run : run + CW'(1);
    end
  end

  assign hi_ok = din  && (run_next == RUN_MAX);
  assign lo_ok = !din && (run_next == RUN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= '0;
      last <= 1'b0;
    end else begin
      run  <= run_next;
      last <= din;
    end
  end
endmodule

// File: rtl/alarma_sirena.sv
// Siren/LED sequencer behind the combinational alarm trigger: debounce,
// entry delay, time-limited siren, re-arm holdoff and an event counter.
module alarma_sirena
  import alarma_pkg::*;
#(
  parameter int unsigned DEB_LEN     = 4,
  parameter int unsigned ENTRY_DELAY = 1000,
  parameter int unsigned SIREN_TIME  = 5000,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic                   trigger,
  output logic                   siren,
  output logic                   led,
  output logic [STATE_W-1:0]     state_o,
  output logic [ALARM_CNT_W-1:0] alarm_count
);
  localparam int unsigned TMAX = (ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_DIV + 1);
  localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SIREN_LAST = TW'(SIREN_TIME - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t                 state, state_next;
  logic [TW-1:0]          timer, timer_next;
  logic [BW-1:0]          blink, blink_next;
  logic                   led_next, siren_next;
  logic [ALARM_CNT_W-1:0] count_next;
  logic                   hi_ok, lo_ok;

  alarma_antirrebote #(.DEB_LEN(DEB_LEN)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (trigger),
    .hi_ok (hi_ok),
    .lo_ok (lo_ok)
  );

  always_comb begin
    state_next = state;
    timer_next = timer;
    count_next = alarm_count;
    if (disarm) begin
      state_next = S_DISARMED;
      timer_next = '0;
    end else begin
      case (state)
        S_DISARMED: if (arm) state_next = S_ARMED;
        S_ARMED: if (hi_ok) begin
          state_next = S_ENTRY;
          timer_next = '0;
        end
        S_ENTRY: if (timer == ENTRY_LAST) begin
          state_next = S_ALARM;
          timer_next = '0;
          if (alarm_count != '1) count_next = alarm_count + 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
        S_ALARM: if (timer == SIREN_LAST) begin
          state_next = S_HOLDOFF;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
        S_HOLDOFF: if (lo_ok) state_next = S_ARMED;
        default: state_next = S_DISARMED;
      endcase
    end

    // Outputs are derived from the next state so they register alongside it.
    led_next   = 1'b0;
    blink_next = '0;
    siren_next = (state_next == S_ALARM);
    case (state_next)
      S_ARMED, S_HOLDOFF: led_next = 1'b1;
      S_ENTRY, S_ALARM: begin
        if (state_next != state) begin
          led_next = 1'b1;
        end else if (blink == BLINK_LAST) begin
          led_next = ~led;
        end else begin
          led_next   = led;
          blink_next = blink + 1'b1;
        end
      end
      default: led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_DISARMED;
      timer       <= '0;
      blink       <= '0;
      led         <= 1'b0;
      siren       <= 1'b0;
      alarm_count <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      blink       <= blink_next;
      led         <= led_next;
      siren       <= siren_next;
      alarm_count <= count_next;
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_alarma_sirena.sv
// Bench for alarma_sirena: a behavioural model pushes expected outputs per
// cycle to a scoreboard, plus scenario-level checks in each test task.
module tb_alarma_sirena;
  localparam int DEB = 2;
  localparam int ED  = 4;
  localparam int ST  = 8;
  localparam int BD  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       trigger = 1'b0;
  logic       siren;
  logic       led;
  logic [2:0] state_o;
  logic [7:0] alarm_count;

  alarma_sirena #(
    .DEB_LEN     (DEB),
    .ENTRY_DELAY (ED),
    .SIREN_TIME  (ST),
    .BLINK_DIV   (BD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .disarm      (disarm),
    .trigger     (trigger),
    .siren       (siren),
    .led         (led),
    .state_o     (state_o),
    .alarm_count (alarm_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       sir;
    logic       led;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int checks = 0;
  int errors = 0;

  // Model: age = cycles the current state has been shown, run = length of the
  // current run of equal trigger samples.
  int   m_state, m_age, m_cnt, m_run;
  logic m_last;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      checks++;
      if ({state_o, siren, led, alarm_count} !== got_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got st=%0d siren=%0b led=%0b cnt=%0d expected st=%0d siren=%0b led=%0b cnt=%0d",
                 $time, state_o, siren, led, alarm_count, got_e.st, got_e.sir, got_e.led, got_e.cnt);
      end
    end
  end

  task automatic model_reset();
    m_state = 0; m_age = 0; m_cnt = 0; m_run = 0; m_last = 1'b0;
    sb.delete();
  endtask

  task automatic step(input logic a, input logic d, input logic t);
    logic hi, lo;
    int nxt;
    exp_t e;
    @(negedge clk);
    arm = a; disarm = d; trigger = t;
    if (t == m_last) m_run++; else m_run = 1;
    m_last = t;
    hi = t && (m_run >= DEB);
    lo = !t && (m_run >= DEB);
    nxt = m_state;
    if (d) nxt = 0;
    else case (m_state)
      0: if (a) nxt = 1;
      1: if (hi) nxt = 2;
      2: if (m_age == ED) nxt = 3;
      3: if (m_age == ST) nxt = 4;
      4: if (lo) nxt = 1;
      default: nxt = 0;
    endcase
    if (m_state == 2 && nxt == 3 && m_cnt < 255) m_cnt++;
    if (nxt == m_state) m_age++; else m_age = 1;
    m_state = nxt;
    e.st  = 3'(m_state);
    e.sir = (m_state == 3);
    if (m_state == 1 || m_state == 4) e.led = 1'b1;
    else if (m_state == 2 || m_state == 3) e.led = (((m_age - 1) / BD) % 2) == 0;
    else e.led = 1'b0;
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({state_o, siren, led, alarm_count} !== 12'd0) begin
      errors++;
      $display("FAIL reset_values got st=%0d siren=%0b led=%0b cnt=%0d expected all 0",
               state_o, siren, led, alarm_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
  endtask

  task automatic test_arm();
    step(1, 0, 0);
    checks++;
    if (state_o !== 3'd1 || led !== 1'b1 || siren !== 1'b0 || alarm_count !== 8'd0) begin
      errors++;
      $display("FAIL arm got st=%0d led=%0b siren=%0b cnt=%0d expected st=1 led=1 siren=0 cnt=0",
               state_o, led, siren, alarm_count);
    end
    step(1, 0, 0);
  endtask

  task automatic test_alarm_sequence();
    int entry_cycles, siren_cycles;
    step(0, 0, 1);
    step(0, 0, 0);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL pulse_ignored got st=%0d expected 1", state_o);
    end
    step(0, 0, 1);
    step(0, 0, 1);
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL entry_on_2nd_high got st=%0d expected 2", state_o);
    end
    entry_cycles = 1;
    siren_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, (i == 0) ? 1'b0 : 1'b1);
      if (state_o == 3'd2) entry_cycles++;
      if (siren === 1'b1) siren_cycles++;
      if (state_o == 3'd4) break;
    end
    checks++;
    if (entry_cycles != ED) begin
      errors++;
      $display("FAIL entry_length got %0d expected %0d", entry_cycles, ED);
    end
    checks++;
    if (siren_cycles != ST) begin
      errors++;
      $display("FAIL siren_length got %0d expected %0d", siren_cycles, ST);
    end
    checks++;
    if (alarm_count !== 8'd1) begin
      errors++;
      $display("FAIL alarm_count_1 got %0d expected 1", alarm_count);
    end
  endtask

  task automatic test_holdoff();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      checks++;
      if (state_o !== 3'd4 || siren !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_hold got st=%0d siren=%0b expected st=4 siren=0", state_o, siren);
      end
    end
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL holdoff_rearm got st=%0d expected 1", state_o);
    end
  endtask

  task automatic test_disarm_entry();
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    checks++;
    if (state_o !== 3'd0 || siren !== 1'b0 || alarm_count !== 8'd1) begin
      errors++;
      $display("FAIL disarm_entry got st=%0d siren=%0b cnt=%0d expected st=0 siren=0 cnt=1",
               state_o, siren, alarm_count);
    end
    step(0, 0, 0);
  endtask

  task automatic test_priority();
    step(1, 1, 0);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL arm_vs_disarm got st=%0d expected 0", state_o);
    end
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL disarm_vs_hi_ok got st=%0d expected 0", state_o);
    end
    step(0, 0, 0);
  endtask

  task automatic test_saturation();
    int n;
    for (int c = 0; c < 256; c++) begin
      step(1, 0, 0);
      n = 0;
      while (m_state != 4 && n < 40) begin
        step(0, 0, 1);
        n++;
      end
      if (m_state != 4) begin
        checks++;
        errors++;
        $display("FAIL saturation_timeout cycle=%0d model_st=%0d expected 4", c, m_state);
      end
      step(0, 0, 0);
      step(0, 0, 0);
    end
    checks++;
    if (alarm_count !== 8'd255) begin
      errors++;
      $display("FAIL alarm_count_sat got %0d expected 255", alarm_count);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    checks++;
    if (siren !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_alarm got st=%0d siren=%0b expected st=3 siren=1", state_o, siren);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (siren !== 1'b0 || state_o !== 3'd0 || led !== 1'b0 || alarm_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got st=%0d siren=%0b led=%0b cnt=%0d expected all 0",
               state_o, siren, led, alarm_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_state got st=%0d expected 0", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_alarm_sequence();
    test_holdoff();
    test_disarm_entry();
    test_priority();
    test_saturation();
    test_async_reset();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
